// File: rtl/jtframe_linedbl_ctrl.sv
// Line-doubler sequencer: measures the native pixel period, emits a 2x pixel
// strobe and ping-pongs two line buffers so each written line is read twice.
module jtframe_linedbl_ctrl #(
  parameter int AW = 9,
  parameter int CW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cen_in,
  input  logic          i_hs_in,
  output logic          o_buf_we,
  output logic [AW-1:0] o_wr_addr,
  output logic          o_wr_bank,
  output logic [AW-1:0] o_rd_addr,
  output logic          o_rd_bank,
  output logic          o_cen_out,
  output logic          o_double,
  output logic          o_de_out,
  output logic          o_hs_out,
  output logic          o_per_err
);

  typedef enum logic {IDLE = 1'b0, PASS = 1'b1} state_t;

  localparam logic [CW-1:0] P_MAX = '1;
  localparam logic [CW-1:0] P_ONE = CW'(1);
  localparam logic [AW-1:0] A_MAX = '1;
  localparam logic [AW-1:0] A_ONE = AW'(1);

  logic [CW-1:0] r_pcnt, r_per;
  logic [CW-1:0] w_pcnt_nxt, w_per_new, w_half;
  logic          r_cen_out, r_per_err;
  logic          w_mid, w_we;

  logic          r_hs_d1, r_hs_d2, w_hs_edge;
  logic [AW-1:0] r_wr_addr, r_rd_addr, r_line_len;
  logic          r_wr_bank, r_rd_bank, r_pass, r_hs_out, w_last;
  state_t        r_state;

  // The mid-period strobe is timed so it shows up in the cycle where pcnt == half.
  always_comb begin
    w_pcnt_nxt = i_cen_in ? '0 : ((r_pcnt == P_MAX) ? r_pcnt : r_pcnt + P_ONE);
    w_per_new  = (r_pcnt == P_MAX) ? P_MAX : r_pcnt + P_ONE;
    w_half     = r_per >> 1;
    w_mid      = !i_cen_in && (r_per > P_ONE) && (w_pcnt_nxt == w_half);
    w_we       = i_cen_in & ~i_hs_in & ~i_rst;
    w_hs_edge  = r_hs_d1 & ~r_hs_d2;
    w_last     = (r_rd_addr == r_line_len - A_ONE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pcnt    <= '0;
      r_per     <= '0;
      r_per_err <= 1'b0;
      r_cen_out <= 1'b0;
    end else begin
      r_pcnt    <= w_pcnt_nxt;
      r_cen_out <= i_cen_in | w_mid;
      if (i_cen_in) begin
        r_per     <= w_per_new;
        r_per_err <= (w_per_new == P_ONE);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hs_d1    <= 1'b0;
      r_hs_d2    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_bank  <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_bank  <= 1'b0;
      r_line_len <= '0;
      r_pass     <= 1'b0;
      r_hs_out   <= 1'b0;
      r_state    <= IDLE;
    end else begin
      r_hs_d1  <= i_hs_in;
      r_hs_d2  <= r_hs_d1;
      r_hs_out <= 1'b0;
      // A new line always restarts reading, even if the previous pass is unfinished.
      if (w_hs_edge) begin
        r_line_len <= r_wr_addr;
        r_wr_addr  <= '0;
        r_wr_bank  <= ~r_wr_bank;
        r_rd_bank  <= r_wr_bank;
        r_rd_addr  <= '0;
        r_pass     <= 1'b0;
        if (r_wr_addr != '0) begin
          r_state  <= PASS;
          r_hs_out <= 1'b1;
        end else begin
          r_state  <= IDLE;
        end
      end else begin
        if (w_we && r_wr_addr != A_MAX) r_wr_addr <= r_wr_addr + A_ONE;
        if (r_state == PASS && r_cen_out) begin
          if (w_last) begin
            r_rd_addr <= '0;
            if (!r_pass) begin
              r_pass   <= 1'b1;
              r_hs_out <= 1'b1;
            end else begin
              r_pass  <= 1'b0;
              r_state <= IDLE;
            end
          end else begin
            r_rd_addr <= r_rd_addr + A_ONE;
          end
        end
      end
    end
  end

  assign o_buf_we  = w_we;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_bank = r_wr_bank;
  assign o_rd_addr = r_rd_addr;
  assign o_rd_bank = r_rd_bank;
  assign o_cen_out = r_cen_out;
  assign o_double  = r_pass;
  assign o_de_out  = (r_state == PASS);
  assign o_hs_out  = r_hs_out;
  assign o_per_err = r_per_err;

endmodule

// File: tb/tb_jtframe_linedbl_ctrl.sv
// Bench for jtframe_linedbl_ctrl: expected read-back sequence is queued at each
// hsync and popped whenever the DUT presents a read pixel.
module tb_jtframe_linedbl_ctrl;
  localparam int AW = 9;
  localparam int CW = 4;
  localparam int AMAX = (1 << AW) - 1;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_cen_in = 1'b0;
  logic          i_hs_in = 1'b0;
  logic          o_buf_we, o_wr_bank, o_rd_bank, o_cen_out, o_double;
  logic          o_de_out, o_hs_out, o_per_err;
  logic [AW-1:0] o_wr_addr, o_rd_addr;
  logic [25:0]   w_outs;

  jtframe_linedbl_ctrl #(.AW(AW), .CW(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cen_in(i_cen_in), .i_hs_in(i_hs_in),
    .o_buf_we(o_buf_we), .o_wr_addr(o_wr_addr), .o_wr_bank(o_wr_bank),
    .o_rd_addr(o_rd_addr), .o_rd_bank(o_rd_bank), .o_cen_out(o_cen_out),
    .o_double(o_double), .o_de_out(o_de_out), .o_hs_out(o_hs_out),
    .o_per_err(o_per_err)
  );

  assign w_outs = {o_buf_we, o_wr_addr, o_wr_bank, o_rd_addr, o_rd_bank,
                   o_cen_out, o_double, o_de_out, o_hs_out, o_per_err};

  always #5 i_clk = ~i_clk;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [AW:0] exp_q[$];
  int          wr_cnt = 0;
  int          exp_hs = 0;
  int          hs_seen = 0;
  int          de_cycles = 0;
  logic        exp_wr_bank = 1'b0;
  logic        exp_rd_bank = 1'b0;
  bit          hit = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // n native pixels, one cen_in every 4 clk; optionally checks the 2x strobe
  // shape and optionally stops once the second pass reaches address 100.
  task automatic px(input int n, input bit chk, input bit stop);
    for (int k = 0; k < n; k++) begin
      i_cen_in = 1'b1;
      tick();
      i_cen_in = 1'b0;
      if (!i_hs_in && wr_cnt < AMAX) wr_cnt++;
      for (int j = 0; j < 3; j++) begin
        @(negedge i_clk);
        if (chk && k >= 2) check("cen_out_x2", o_cen_out, (j != 1));
        if (stop && o_double && o_rd_addr == AW'(100)) begin
          hit = 1'b1;
          return;
        end
        tick();
      end
    end
  endtask

  task automatic hsync(input int hold);
    check("q_drained", exp_q.size(), 0);
    if (wr_cnt > 0) begin
      for (int p = 0; p < 2; p++)
        for (int a = 0; a < wr_cnt; a++) exp_q.push_back({p[0], AW'(a)});
      exp_hs += 2;
    end
    exp_rd_bank = exp_wr_bank;
    exp_wr_bank = ~exp_wr_bank;
    wr_cnt = 0;
    i_hs_in = 1'b1;
    for (int k = 0; k < hold; k++) begin
      i_cen_in = 1'b1;
      tick();
      i_cen_in = 1'b0;
      repeat (3) tick();
    end
    i_hs_in = 1'b0;
    @(negedge i_clk);
    check("wr_bank", o_wr_bank, exp_wr_bank);
    check("rd_bank", o_rd_bank, exp_rd_bank);
    check("wr_addr_restart", o_wr_addr, 0);
    tick();
  endtask

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_hs_out) begin
        hs_seen++;
        check("hs_out_addr0", o_rd_addr, 0);
      end
      if (o_de_out) de_cycles++;
      if (o_cen_out && o_de_out) begin
        check("rd_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("rd_seq", {o_double, o_rd_addr}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, hs0;
    repeat (3) tick();
    @(negedge i_clk);
    check("reset_outs", w_outs, 0);
    tick();
    i_rst = 1'b0;
    repeat (2) tick();

    // period 4: strobe every 2 clk
    px(8, 1'b1, 1'b0);
    @(negedge i_clk);
    check("wr_addr_8", o_wr_addr, 8);
    check("per_err_p4", o_per_err, 0);
    check("de_idle", o_de_out, 0);
    tick();

    // period 1: cen_out is cen_in delayed, no mid pulse
    i_cen_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      if (k > 0) check("cen_out_p1", o_cen_out, 1);
      tick();
    end
    i_cen_in = 1'b0;
    wr_cnt += 6;
    @(negedge i_clk);
    check("cen_out_p1_tail", o_cen_out, 1);
    tick();
    @(negedge i_clk);
    check("cen_out_p1_none", o_cen_out, 0);
    check("per_err_p1", o_per_err, 1);
    tick();
    @(negedge i_clk);
    check("cen_out_p1_none2", o_cen_out, 0);
    tick();

    px(2, 1'b0, 1'b0);
    @(negedge i_clk);
    check("per_err_clear", o_per_err, 0);
    check("wr_addr_16", o_wr_addr, 16);
    tick();

    hsync(2);
    px(320, 1'b0, 1'b0);
    hsync(2);
    hit = 1'b0;
    px(400, 1'b0, 1'b1);
    check("mid_reached", hit, 1);

    // async reset in the middle of the second pass
    #1 i_rst = 1'b1;
    #1 check("rst_async", w_outs, 0);
    exp_q.delete();
    exp_hs = 0;
    hs_seen = 0;
    wr_cnt = 0;
    exp_wr_bank = 1'b0;
    exp_rd_bank = 1'b0;
    repeat (2) tick();
    i_rst = 1'b0;
    tick();

    px(8, 1'b0, 1'b0);
    hsync(2);
    px(600, 1'b0, 1'b0);
    @(negedge i_clk);
    check("wr_addr_sat", o_wr_addr, AMAX);
    tick();
    hsync(520);
    @(negedge i_clk);
    check("q_drained_511", exp_q.size(), 0);
    check("de_after_511", o_de_out, 0);
    tick();

    // zero-length line
    dc = de_cycles;
    hs0 = hs_seen;
    hsync(2);
    repeat (8) tick();
    @(negedge i_clk);
    check("zero_len_de", de_cycles, dc);
    check("zero_len_hs", hs_seen, hs0);
    check("hs_out_total", hs_seen, exp_hs);
    check("q_final", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
